// File: rtl/alu_ctrl.sv
// alu_ctrl: command-side initiator for a 16-bit combinational ALU.
// Accepts one op per command handshake, drives the ALU operands/opcode,
// waits EXEC_CYCLES settle cycles, captures out/hi/flags and presents them on
// a response handshake. An accumulator lets ops chain without resending A.
//
// Parameters:
//   EXEC_CYCLES  ALU settle cycles before capture (>=1)
//   ACC_INIT     reset value of the accumulator and the hi register
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_op, cmd_use_acc           ALU opcode, take A from the accumulator
//   cmd_a, cmd_b                  operands
//   alu_a, alu_b, alu_ins         registered drive to the ALU
//   alu_out, alu_hi, alu_flags    ALU results {div_err, overflow, carry}
//   rsp_valid/rsp_ready           response handshake
//   rsp_data, rsp_hi, rsp_flags   captured results
//   acc                           accumulator
// Optional (macro ALU_CTRL_STICKY_FLAGS_EN):
//   flags_clr     clears sticky_flags (wins over a same-cycle capture)
//   sticky_flags  OR of all captured flags since reset/clear
module alu_ctrl #(
  parameter int unsigned EXEC_CYCLES = 1,
  parameter logic [15:0] ACC_INIT    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic        cmd_use_acc,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_ins,
  input  logic [15:0] alu_out,
  input  logic [15:0] alu_hi,
  input  logic [2:0]  alu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [15:0] rsp_hi,
  output logic [2:0]  rsp_flags,
`ifdef ALU_CTRL_STICKY_FLAGS_EN
  input  logic        flags_clr,
  output logic [2:0]  sticky_flags,
`endif
  output logic [15:0] acc
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam int unsigned   CW   = $clog2(EXEC_CYCLES + 1) + 1;
  localparam logic [CW-1:0] LAST = CW'(EXEC_CYCLES);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          capture;
  logic          op_ok;
  logic [15:0]   cap_data;
  logic [2:0]    cap_flags;

  // The counter advances on each EXEC edge and capture happens on the edge
  // after it reaches EXEC_CYCLES, giving accept->rsp_valid of EXEC_CYCLES+1.
  always_comb begin
    capture   = (state == EXEC) && (cnt == LAST);
    op_ok     = (alu_ins != 4'd0) && (alu_ins <= 4'd9);
    cap_data  = op_ok ? alu_out : '0;
    cap_flags = op_ok ? alu_flags : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_flags <= '0;
      rsp_hi    <= ACC_INIT;
      acc       <= ACC_INIT;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ins   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            alu_a     <= cmd_use_acc ? acc : cmd_a;
            alu_b     <= cmd_b;
            alu_ins   <= cmd_op;
            cnt       <= '0;
            cmd_ready <= 1'b0;
            state     <= EXEC;
          end
        end
        EXEC: begin
          if (capture) begin
            rsp_data  <= cap_data;
            rsp_flags <= cap_flags;
            if (op_ok) acc <= alu_out;
            if (alu_ins == 4'd3) rsp_hi <= alu_hi;
            alu_ins   <= '0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
          alu_ins   <= '0;
        end
      endcase
    end
  end

`ifdef ALU_CTRL_STICKY_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            sticky_flags <= '0;
    else if (flags_clr) sticky_flags <= '0;
    else if (capture)   sticky_flags <= sticky_flags | cap_flags;
  end
`endif

endmodule
